// File: rtl/bnn_pkg.sv
// Shared BNN constants: layer sizes, layer codes and the weight-loader FSM states.
// Used by the weight loader and the classifier top.
package bnn_pkg;

    localparam int N1        = 90;
    localparam int N2        = 1080;
    localparam int NFC       = 10;
    localparam int CFC       = 48;
    localparam int BW        = 8;
    localparam int REC_BYTES = 5;

    localparam logic [1:0] LAYER_CONV1 = 2'd1;
    localparam logic [1:0] LAYER_CONV2 = 2'd2;
    localparam logic [1:0] LAYER_FC    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        DONE    = 2'd3
    } wl_state_t;

    // FC record address packs chunk above neuron.
    function automatic logic [10:0] fc_addr(input logic [3:0] neuron, input logic [5:0] chunk);
        return {1'b0, chunk, neuron};
    endfunction

endpackage

// File: rtl/weight_loader.sv
// Assembles 5-byte weight records from a byte stream and writes them, one strobe
// per record, into the classifier's conv1 / conv2 / fc kernel stores.
module weight_loader
    import bnn_pkg::*;
#(
    parameter int bW = BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          kernel_in_valid,
    output logic [1:0]    kernel_layer,
    output logic [10:0]   kernel_addr,
    output logic [bW-1:0] kernel_offset,
    output logic [24:0]   kernel_bits,
    output logic          busy,
    output logic          load_done
);

    wl_state_t       state, state_nxt;
    logic [2:0]      byte_cnt;
    logic [3:0][7:0] rec_buf;
    logic [1:0]      layer;
    logic [10:0]     rec_idx;
    logic [3:0]      neuron;
    logic [5:0]      chunk;

    logic beat, last_beat, last_rec;

    assign beat      = s_valid && s_ready;
    assign last_beat = beat && (byte_cnt == 3'(REC_BYTES - 1));
    assign last_rec  = (layer == LAYER_FC) && (neuron == 4'(NFC - 1)) && (chunk == 6'(CFC - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (last_beat) state_nxt = ISSUE;
            ISSUE:   state_nxt = last_rec ? DONE : COLLECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decodes are masked by rst so nothing is strobed or accepted in a reset cycle.
    always_comb begin
        s_ready         = 1'b0;
        kernel_in_valid = 1'b0;
        busy            = 1'b0;
        if (rst) begin
            s_ready         = (state == COLLECT);
            kernel_in_valid = (state == ISSUE);
            busy            = (state == COLLECT) || (state == ISSUE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt      <= '0;
            rec_buf       <= '0;
            layer         <= '0;
            rec_idx       <= '0;
            neuron        <= '0;
            chunk         <= '0;
            load_done     <= 1'b0;
            kernel_layer  <= '0;
            kernel_addr   <= '0;
            kernel_offset <= '0;
            kernel_bits   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt  <= '0;
                        layer     <= LAYER_CONV1;
                        rec_idx   <= '0;
                        neuron    <= '0;
                        chunk     <= '0;
                        load_done <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (last_beat) begin
                        // Final byte goes straight to the output; only its bit 0 is kept.
                        byte_cnt      <= '0;
                        kernel_layer  <= layer;
                        kernel_addr   <= (layer == LAYER_FC) ? fc_addr(neuron, chunk) : rec_idx;
                        kernel_offset <= rec_buf[0];
                        kernel_bits   <= {s_data[0], rec_buf[3], rec_buf[2], rec_buf[1]};
                    end else if (beat) begin
                        rec_buf[byte_cnt[1:0]] <= s_data;
                        byte_cnt               <= byte_cnt + 3'd1;
                    end
                end
                ISSUE: begin
                    if (layer == LAYER_CONV1) begin
                        if (rec_idx == 11'(N1 - 1)) begin
                            layer   <= LAYER_CONV2;
                            rec_idx <= '0;
                        end else begin
                            rec_idx <= rec_idx + 11'd1;
                        end
                    end else if (layer == LAYER_CONV2) begin
                        if (rec_idx == 11'(N2 - 1)) begin
                            layer   <= LAYER_FC;
                            rec_idx <= '0;
                            neuron  <= '0;
                            chunk   <= '0;
                        end else begin
                            rec_idx <= rec_idx + 11'd1;
                        end
                    end else begin
                        if (chunk == 6'(CFC - 1)) begin
                            chunk  <= '0;
                            neuron <= neuron + 4'd1;
                        end else begin
                            chunk <= chunk + 6'd1;
                        end
                    end
                    if (last_rec) load_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: single records, full loads with and without
// stream gaps, start/valid ignore rules and mid-load reset.
module tb_weight_loader;
    import bnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        kernel_in_valid;
    logic [1:0]  kernel_layer;
    logic [10:0] kernel_addr;
    logic [7:0]  kernel_offset;
    logic [24:0] kernel_bits;
    logic        busy;
    logic        load_done;

    int total = 0;
    int bad   = 0;
    int strb_cnt = 0;
    int pend = 0;
    bit auto_chk = 0;
    logic [1:0]  lst_layer;
    logic [10:0] lst_addr;
    logic [7:0]  lst_off;
    logic [24:0] lst_bits;
    logic [1:0]  l90, l1170;
    logic [10:0] a90, a1170;

    always #5 clk = ~clk;

    weight_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .kernel_in_valid(kernel_in_valid), .kernel_layer(kernel_layer),
        .kernel_addr(kernel_addr), .kernel_offset(kernel_offset),
        .kernel_bits(kernel_bits), .busy(busy), .load_done(load_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pb(input int r, input int k);
        int v;
        if (k == 0) v = r ^ 32'h5A;
        else        v = (r * 7 + k * 37) ^ (r >> 3);
        return v[7:0];
    endfunction

    function automatic logic [24:0] exp_bits(input int r);
        logic [7:0] b4;
        b4 = pb(r, 4);
        return {b4[0], pb(r, 3), pb(r, 2), pb(r, 1)};
    endfunction

    task automatic exp_la(input int idx, output logic [1:0] l, output logic [10:0] a);
        int j, nr, ch;
        if (idx < N1) begin
            l = 2'd1; a = 11'(idx);
        end else if (idx < N1 + N2) begin
            l = 2'd2; a = 11'(idx - N1);
        end else begin
            j = idx - N1 - N2; nr = j / CFC; ch = j % CFC;
            l = 2'd3; a = 11'(ch * 16 + nr);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0]  el;
        logic [10:0] ea;
        if (s_valid && s_ready) pend++;
        if (kernel_in_valid) begin
            if (auto_chk) begin
                exp_la(strb_cnt, el, ea);
                chk("layer", 32'(kernel_layer), 32'(el));
                chk("addr", 32'(kernel_addr), 32'(ea));
                chk("offset", 32'(kernel_offset), 32'(pb(strb_cnt, 0)));
                chk("bits", 32'(kernel_bits), 32'(exp_bits(strb_cnt)));
            end
            chk("bytes_per_strobe", 32'(pend), 32'd5);
            pend = 0;
            lst_layer = kernel_layer; lst_addr = kernel_addr;
            lst_off = kernel_offset;  lst_bits = kernel_bits;
            if (strb_cnt == 90)   begin l90 = kernel_layer;   a90 = kernel_addr;   end
            if (strb_cnt == 1170) begin l1170 = kernel_layer; a1170 = kernel_addr; end
            strb_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pend = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bit hs;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1; s_data = b;
        n = 0; hs = 0;
        while (!hs && n < 20) begin
            @(negedge clk); hs = s_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic send_rec(input int r, input bit rnd);
        for (int k = 0; k < 5; k++)
            send_byte(pb(r, k), rnd ? int'($urandom_range(0, 1)) : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(kernel_in_valid), 0);
        chk({tag, "_ready"}, 32'(s_ready), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(load_done), 0);
        chk({tag, "_layer"}, 32'(kernel_layer), 0);
        chk({tag, "_addr"},  32'(kernel_addr), 0);
        chk({tag, "_off"},   32'(kernel_offset), 0);
        chk({tag, "_bits"},  32'(kernel_bits), 0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk_zero("rst0");

        // Directed first records, hand-computed payloads
        strb_cnt = 0; auto_chk = 0;
        @(posedge clk); #1;
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        send_byte(8'h05, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        send_byte(8'hFF, 0); send_byte(8'h01, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rec0_count", 32'(strb_cnt), 1);
        chk("rec0_layer", 32'(lst_layer), 1);
        chk("rec0_addr", 32'(lst_addr), 0);
        chk("rec0_off", 32'(lst_off), 32'h05);
        chk("rec0_bits", 32'(lst_bits), 32'h1FFFFFF);
        chk("hold_bits", 32'(kernel_bits), 32'h1FFFFFF);
        chk("hold_valid", 32'(kernel_in_valid), 0);
        @(posedge clk); #1;
        send_byte(8'h11, 0); send_byte(8'hAA, 0); send_byte(8'h55, 0);
        send_byte(8'h33, 0); send_byte(8'hFE, 0);
        @(negedge clk); @(negedge clk);
        chk("rec1_addr", 32'(lst_addr), 1);
        chk("rec1_off", 32'(lst_off), 32'h11);
        chk("rec1_bits", 32'(lst_bits), 32'h003355AA);

        // Valid held in IDLE, start pulsed mid-record
        do_reset();
        s_valid = 1'b1; s_data = 8'hEE;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", 32'(s_ready), 0);
        end
        chk("idle_no_accept", 32'(pend), 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        strb_cnt = 0; auto_chk = 1;
        pulse_start();
        send_byte(pb(0, 0), 0); send_byte(pb(0, 1), 0);
        pulse_start();
        send_byte(pb(0, 2), 0); send_byte(pb(0, 3), 0); send_byte(pb(0, 4), 0);
        send_rec(1, 0);
        pulse_start();
        send_rec(2, 0);
        @(negedge clk); @(negedge clk);
        chk("restart_ignored_count", 32'(strb_cnt), 3);
        chk("restart_ignored_addr", 32'(lst_addr), 2);

        // Full load, continuous stream
        do_reset();
        strb_cnt = 0;
        pulse_start();
        for (int r = 0; r < 1650; r++) send_rec(r, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_count", 32'(strb_cnt), 1650);
        chk("full_last_layer", 32'(lst_layer), 3);
        chk("full_last_addr", 32'(lst_addr), 32'h2F9);
        chk("full_l90", 32'(l90), 2);
        chk("full_a90", 32'(a90), 0);
        chk("full_l1170", 32'(l1170), 3);
        chk("full_a1170", 32'(a1170), 0);
        chk("full_done", 32'(load_done), 1);
        chk("full_busy", 32'(busy), 0);
        chk("full_ready", 32'(s_ready), 0);

        // Full load with random stream gaps, restarted without reset
        @(posedge clk); #1;
        strb_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("restart_done_clr", 32'(load_done), 0);
        chk("restart_busy", 32'(busy), 1);
        @(posedge clk); #1;
        for (int r = 0; r < 1650; r++) send_rec(r, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gap_count", 32'(strb_cnt), 1650);
        chk("gap_last_addr", 32'(lst_addr), 32'h2F9);
        chk("gap_done", 32'(load_done), 1);

        // Reset in the middle of record 500
        @(posedge clk); #1;
        strb_cnt = 0;
        pulse_start();
        for (int r = 0; r < 500; r++) send_rec(r, 0);
        send_byte(pb(500, 0), 0); send_byte(pb(500, 1), 0); send_byte(pb(500, 2), 0);
        do_reset();
        @(negedge clk);
        chk_zero("abort");
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_no_strobe", 32'(strb_cnt), 500);
        @(posedge clk); #1;
        strb_cnt = 0;
        pulse_start();
        send_rec(0, 0);
        @(negedge clk); @(negedge clk);
        chk("after_abort_count", 32'(strb_cnt), 1);
        chk("after_abort_layer", 32'(lst_layer), 1);
        chk("after_abort_addr", 32'(lst_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
